// File: rtl/uart_rx.sv
// UART receiver: 2-FF synchronised line, mid-bit sampling on baud_sample_tick, one-cycle result pulses.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_busy,
  output logic                 frame_error,
  output logic                 parity_error
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;
`endif

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d, tick_inc;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_busy_q, rx_busy_d;
  logic                   frame_error_q, frame_error_d;
  logic                   par_fail;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   parity_error_q, parity_error_d;
  assign par_fail = par_q;
`else
  assign par_fail = 1'b0;
`endif

  assign tick_inc = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);

  always_comb begin
    state_d       = state_q;
    tick_cnt_d    = tick_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d          = par_q;
    parity_error_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (baud_sample_tick && !rx_s_q) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (baud_sample_tick) begin
          if (tick_cnt_q == TICK_MID) begin
            // A high line at mid-start means the low was a glitch.
            if (rx_s_q) begin
              state_d = ST_IDLE;
            end else begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
              par_d      = 1'b0;
`endif
            end
          end else begin
            tick_cnt_d = tick_inc;
          end
        end
      end
      ST_DATA: begin
        if (baud_sample_tick) begin
          tick_cnt_d = tick_inc;
          if (tick_cnt_q == TICK_LAST) begin
            shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
`ifdef UART_RX_PARITY_EN
            par_d     = par_q ^ rx_s_q;
            if (bit_cnt_q == BIT_LAST) state_d = ST_PARITY;
`else
            if (bit_cnt_q == BIT_LAST) state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (baud_sample_tick) begin
          tick_cnt_d = tick_inc;
          if (tick_cnt_q == TICK_LAST) begin
            par_d   = par_q ^ rx_s_q;
            state_d = ST_STOP;
          end
        end
      end
`endif
      ST_STOP: begin
        if (baud_sample_tick) begin
          tick_cnt_d = tick_inc;
          if (tick_cnt_q == TICK_LAST) begin
            rx_data_d     = shift_q;
            frame_error_d = !rx_s_q;
            rx_valid_d    = rx_s_q && !par_fail;
`ifdef UART_RX_PARITY_EN
            parity_error_d = par_fail;
`endif
            state_d = rx_s_q ? ST_IDLE : ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    rx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q     <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= ST_IDLE;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_busy_q     <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q          <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      rx_meta_q     <= rx;
      rx_s_q        <= rx_meta_q;
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_busy_q     <= rx_busy_d;
      frame_error_q <= frame_error_d;
`ifdef UART_RX_PARITY_EN
      par_q          <= par_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign rx_busy     = rx_busy_q;
  assign frame_error = frame_error_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, an expected-result queue checked every cycle, literal spot checks.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int TICK_DIV = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          baud_sample_tick = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, rx_busy, frame_error, parity_error;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .baud_sample_tick(baud_sample_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_error(frame_error), .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       cur;
  logic [7:0] model_data = 8'h00;
  logic       rst_prev = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_valid = 0;
  int         n_fe = 0;
  int         n_pe = 0;
  int         tick_div = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      baud_sample_tick = (tick_div == TICK_DIV - 1);
      tick_div = (tick_div == TICK_DIV - 1) ? 0 : tick_div + 1;
    end
  end

  // Every cycle: any result pulse must match the next queued frame, otherwise rx_data must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && rst_prev) begin
        if (rx_valid || frame_error || parity_error) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {29'd0, rx_valid, frame_error, parity_error}, 32'd0);
          end else begin
            cur = exp_q.pop_front();
            check("pulse_data", rx_data, cur.data);
            check("pulse_valid", rx_valid, !(cur.fe || cur.pe));
            check("pulse_frame_error", frame_error, cur.fe);
            check("pulse_parity_error", parity_error, cur.pe);
            model_data = cur.data;
            $display("frame data=%02h valid=%0b fe=%0b pe=%0b", rx_data, rx_valid, frame_error, parity_error);
          end
          if (rx_valid) n_valid++;
          if (frame_error) n_fe++;
          if (parity_error) n_pe++;
        end else begin
          check("hold_data", rx_data, model_data);
        end
      end
      rst_prev = rst;
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_sample_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive_bit(input logic b, input string name);
    rx = b;
    wait_ticks(OS / 2);
    check(name, rx_busy, 1);
    wait_ticks(OS / 2);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0, "busy_start");
    for (int i = 0; i < DB; i++) drive_bit(d[i], "busy_data");
`ifdef UART_RX_PARITY_EN
    drive_bit(par, "busy_parity");
    exp_q.push_back('{data: d, fe: !stop, pe: (^d) ^ par});
`else
    exp_q.push_back('{data: d, fe: !stop, pe: 1'b0});
`endif
    drive_bit(stop, "busy_stop");
    if (stop) check("busy_after_stop", rx_busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rx_busy"}, rx_busy, 0);
    check({tag, "_frame_error"}, frame_error, 0);
    check({tag, "_parity_error"}, parity_error, 0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    wait_ticks(4);

    // Good frame.
    send_frame(8'hA5, 1'b0, 1'b1);
    check("lit_A5", rx_data, 8'hA5);
    wait_ticks(OS);

    // Glitch: 4 ticks low.
    rx = 1'b0;
    wait_ticks(3);
    check("glitch_busy_rise", rx_busy, 1);
    wait_ticks(1);
    rx = 1'b1;
    wait_ticks(8);
    check("glitch_busy_fall", rx_busy, 0);
    check("glitch_data_kept", rx_data, 8'hA5);
    wait_ticks(OS);

    // Frame error followed by a held-low line, then recovery.
    send_frame(8'h3C, 1'b0, 1'b0);
    check("lit_3C", rx_data, 8'h3C);
    wait_ticks(3 * OS);
    check("break_busy", rx_busy, 1);
    rx = 1'b1;
    wait_ticks(2);
    check("break_exit", rx_busy, 0);
    wait_ticks(OS);
    send_frame(8'h55, 1'b0, 1'b1);
    check("lit_55", rx_data, 8'h55);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1);
    check("lit_00", rx_data, 8'h00);
    send_frame(8'hFF, 1'b0, 1'b1);
    check("lit_FF", rx_data, 8'hFF);
    wait_ticks(OS);

    // Reset in the middle of data bit 4 of 0x81.
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      wait_ticks(OS);
    end
    rx = 1'b0;
    wait_ticks(OS / 2);
    check("mid_busy", rx_busy, 1);
    rst = 1'b0;
    rx = 1'b1;
    model_data = 8'h00;
    exp_q.delete();
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    wait_ticks(20);
    check_all_zero("post_reset");
    send_frame(8'h42, 1'b0, 1'b1);
    check("lit_42", rx_data, 8'h42);
    wait_ticks(OS);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    check("lit_07_bad", rx_data, 8'h07);
    wait_ticks(OS);
    send_frame(8'h07, 1'b1, 1'b1);
    check("lit_07_good", rx_data, 8'h07);
    wait_ticks(OS);
    check("count_valid", n_valid, 6);
    check("count_parity_error", n_pe, 1);
`else
    check("count_valid", n_valid, 5);
    check("count_parity_error", n_pe, 0);
`endif
    check("count_frame_error", n_fe, 1);
    check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
